// File: rtl/mux_scan_if.sv
// Handshake/bus bundle between the mux scan sequencer (master) and the mux/downstream side (slave).
interface mux_scan_if;
    logic       start;
    logic [2:0] sel;
    logic       mux_in;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;

    modport master (
        input  start,
        input  mux_in,
        input  ready,
        output sel,
        output data,
        output valid,
        output busy
    );

    modport slave (
        output start,
        output mux_in,
        output ready,
        input  sel,
        input  data,
        input  valid,
        input  busy
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Sequencer for an 8:1 single-bit mux: steps sel 0..7, settles, samples, then offers the word on valid/ready.
// Optional MUX_SCAN_AUTO_RESCAN_EN: the DONE handshake restarts the scan immediately instead of returning to IDLE.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux_scan_if.master    scan_io
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       sel_q,   sel_d;
    logic [7:0]       acc_q,   acc_d;
    logic [7:0]       data_q,  data_d;

    // Each accumulator bit only captures mux_in during the SAMPLE cycle of its own channel.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_acc
            assign acc_d[gi] = (state_q == SAMPLE && sel_q == 3'(gi)) ? scan_io.mux_in
                                                                     : acc_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 3'd0;
            acc_q   <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        data_d  = data_q;

        unique case (state_q)
            IDLE: begin
                sel_d = 3'd0;
                if (scan_io.start) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end

            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                if (sel_q != 3'd7) begin
                    sel_d   = sel_q + 3'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    // Bit 7 is still in flight into acc, so take it straight from the mux.
                    data_d  = {scan_io.mux_in, acc_q[6:0]};
                    state_d = DONE;
                end
            end

            DONE: begin
                sel_d = 3'd7;
                if (scan_io.ready) begin
                    sel_d = 3'd0;
`ifdef MUX_SCAN_AUTO_RESCAN_EN
                    cnt_d   = '0;
                    state_d = SETTLE;
`else
                    state_d = IDLE;
`endif
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = 3'd0;
                cnt_d   = '0;
            end
        endcase
    end

    assign scan_io.sel   = sel_q;
    assign scan_io.data  = data_q;
    assign scan_io.valid = (state_q == DONE);
    assign scan_io.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: stimulus pushes expected words/edges, a negedge monitor pops on each valid.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pat = 8'hA5;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    typedef struct {
        logic [7:0] data;
        int         edge_no;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic valid_prev = 1'b0;

    mux_scan_if bus ();

    mux_scan_ctrl #(
        .SETTLE_CYCLES(2),
        .CNT_W        (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .scan_io(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mux model: the selected channel of the current pattern.
    always_comb bus.mux_in = pat[bus.sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; the word is expected 24 edges after the edge that samples start.
    task automatic start_scan(input logic [7:0] p, input bit expect_result);
        exp_t e;
        pat       = p;
        bus.start = 1'b1;
        if (expect_result) begin
            e.data    = p;
            e.edge_no = cyc + 1 + 24;
            exp_q.push_back(e);
        end
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (bus.valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (bus.valid !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL valid_timeout: got valid=%b after %0d cycles, expected 1", bus.valid, budget);
        end
    endtask

    always @(negedge clk) begin
        if (bus.valid === 1'b1 && valid_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got data=%h at edge %0d, expected no output", bus.data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn: data=%h edge=%0d (expected data=%h edge=%0d)",
                         bus.data, cyc, mon_e.data, mon_e.edge_no);
                check("scan_data", 32'(bus.data), 32'(mon_e.data));
                check("scan_latency", cyc, mon_e.edge_no);
            end
        end
        valid_prev <= bus.valid;
    end

    initial begin
        bus.start = 1'b0;
        bus.ready = 1'b0;

        // Reset takes effect with no clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_sel",   32'(bus.sel),   32'd0);
        check("rst_data",  32'(bus.data),  32'h00);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_sel",   32'(bus.sel),   32'd0);
        check("idle_data",  32'(bus.data),  32'h00);
        check("idle_valid", 32'(bus.valid), 32'd0);
        check("idle_busy",  32'(bus.busy),  32'd0);

`ifndef MUX_SCAN_AUTO_RESCAN_EN
        // Basic scan: each channel held 3 cycles, immediate handshake.
        bus.ready = 1'b1;
        start_scan(8'hA5, 1'b1);
        for (int j = 0; j < 24; j++) begin
            check("sel_step", 32'(bus.sel), 32'(j / 3));
            check("busy_scan", 32'(bus.busy), 32'd1);
            tick();
        end
        check("done_valid", 32'(bus.valid), 32'd1);
        check("done_sel",   32'(bus.sel),   32'd7);
        tick();
        check("hs_valid", 32'(bus.valid), 32'd0);
        check("hs_busy",  32'(bus.busy),  32'd0);
        check("hs_sel",   32'(bus.sel),   32'd0);
        check("hs_data",  32'(bus.data),  32'hA5);

        // Backpressure: word and sel hold while ready is low.
        bus.ready = 1'b0;
        start_scan(8'h5A, 1'b1);
        wait_valid(40);
        for (int j = 0; j < 10; j++) begin
            check("bp_valid", 32'(bus.valid), 32'd1);
            check("bp_data",  32'(bus.data),  32'h5A);
            check("bp_sel",   32'(bus.sel),   32'd7);
            check("bp_busy",  32'(bus.busy),  32'd1);
            tick();
        end
        bus.ready = 1'b1;
        tick();
        check("bp_hs_valid", 32'(bus.valid), 32'd0);
        check("bp_hs_busy",  32'(bus.busy),  32'd0);
        tick();
        check("bp_idle_busy", 32'(bus.busy), 32'd0);
        check("bp_idle_data", 32'(bus.data), 32'h5A);

        // Second start mid-scan must be ignored.
        start_scan(8'hC3, 1'b1);
        repeat (9) tick();
        check("mid_sel", 32'(bus.sel), 32'd3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_valid(30);
        repeat (31) tick();
        check("single_busy",  32'(bus.busy), 32'd0);
        check("single_queue", exp_q.size(), 32'd0);

        // Asynchronous abort at channel 4, then a clean scan.
        start_scan(8'hA5, 1'b0);
        for (int j = 0; j < 30 && bus.sel !== 3'd4; j++) tick();
        check("abort_at_sel", 32'(bus.sel), 32'd4);
        #3 rst = 1'b1;
        #1;
        check("abort_sel",   32'(bus.sel),   32'd0);
        check("abort_data",  32'(bus.data),  32'h00);
        check("abort_valid", 32'(bus.valid), 32'd0);
        check("abort_busy",  32'(bus.busy),  32'd0);
        #2 rst = 1'b0;
        tick();
        start_scan(8'h3C, 1'b1);
        wait_valid(30);
        tick();
        check("post_abort_busy", 32'(bus.busy), 32'd0);
        check("post_abort_data", 32'(bus.data), 32'h3C);
`else
        // Auto-rescan: the handshake restarts the scan; start has no further effect.
        bus.ready = 1'b1;
        start_scan(8'hA5, 1'b1);
        repeat (6) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_valid(30);
        pat = 8'h3C;
        mon_e.data    = 8'h3C;
        mon_e.edge_no = cyc + 25;
        exp_q.push_back(mon_e);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("rescan_sel",   32'(bus.sel),   32'd0);
        check("rescan_busy",  32'(bus.busy),  32'd1);
        check("rescan_valid", 32'(bus.valid), 32'd0);
        repeat (10) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_valid(30);
        bus.ready = 1'b0;
        check("rescan_data", 32'(bus.data), 32'h3C);
        repeat (5) tick();
        check("rescan_hold_valid", 32'(bus.valid), 32'd1);
        check("rescan_hold_busy",  32'(bus.busy),  32'd1);
`endif

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
